// File: rtl/sort_ctrl_fsm.sv
// Sequencer for the 4-entry descending bubble-sort datapath.
// Define SORT_CTRL_STEP_EN to add a STEP input that gates each compare.
module sort_ctrl_fsm #(
   parameter int MAX_PASS = 4,
   parameter int CNT_W    = 4
) (
   input  logic             CLK,
   input  logic             CLR,
   input  logic             START,
`ifdef SORT_CTRL_STEP_EN
   input  logic             STEP,
`endif
   input  logic [2:0]       LT,
   output logic [5:0]       SEL,
   output logic [3:0]       LD,
   output logic             BUSY,
   output logic             DONE,
   output logic             ERR,
   output logic [CNT_W-1:0] SWAP_CNT,
   output logic [CNT_W-1:0] PASS_CNT
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LOAD = 3'd1;
   localparam logic [2:0] S_CMP0 = 3'd2;
   localparam logic [2:0] S_CMP1 = 3'd3;
   localparam logic [2:0] S_CMP2 = 3'd4;
   localparam logic [2:0] S_DONE = 3'd5;

   localparam logic [CNT_W-1:0] PASS_MAX = CNT_W'(MAX_PASS);

   logic [2:0]       r_state;
   logic [2:0]       w_state_nxt;
   logic             r_start_q;
   logic             r_swap;
   logic             r_err;
   logic [CNT_W-1:0] r_swap_cnt;
   logic [CNT_W-1:0] r_pass_cnt;

   logic             w_start_edge;
   logic             w_adv;
   logic             w_lt_cur;
   logic             w_do_swap;
   logic             w_pass_swapped;
   logic             w_last;
   logic [CNT_W-1:0] w_pass_nxt;

   assign w_start_edge = START & ~r_start_q;

`ifdef SORT_CTRL_STEP_EN
   logic r_step_q;
   assign w_adv = STEP & ~r_step_q;
`else
   assign w_adv = 1'b1;
`endif

   always_comb begin
      w_lt_cur = 1'b0;
      case (r_state)
         S_CMP0:  w_lt_cur = LT[0];
         S_CMP1:  w_lt_cur = LT[1];
         S_CMP2:  w_lt_cur = LT[2];
         default: w_lt_cur = 1'b0;
      endcase
   end

   assign w_do_swap      = w_adv & w_lt_cur;
   assign w_pass_nxt     = r_pass_cnt + 1'b1;
   assign w_pass_swapped = r_swap | LT[2];
   assign w_last         = (w_pass_nxt >= PASS_MAX);

   // Compare-state SEL/LD are Mealy: they follow LT within the cycle
   always_comb begin
      w_state_nxt = r_state;
      SEL         = '0;
      LD          = '0;
      case (r_state)
         S_IDLE: if (w_start_edge) w_state_nxt = S_LOAD;
         S_LOAD: begin
            LD          = 4'b1111;
            w_state_nxt = S_CMP0;
         end
         S_CMP0: if (w_adv) begin
            w_state_nxt = S_CMP1;
            if (LT[0]) begin
               SEL = 6'b000011;
               LD  = 4'b0011;
            end
         end
         S_CMP1: if (w_adv) begin
            w_state_nxt = S_CMP2;
            if (LT[1]) begin
               SEL = 6'b010100;
               LD  = 4'b0110;
            end
         end
         S_CMP2: if (w_adv) begin
            if (LT[2]) begin
               SEL = 6'b101000;
               LD  = 4'b1100;
            end
            if (w_pass_swapped && !w_last) w_state_nxt = S_CMP0;
            else                           w_state_nxt = S_DONE;
         end
         S_DONE: if (w_start_edge) w_state_nxt = S_LOAD;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Start history resets high so a button held through reset is ignored
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         r_state    <= S_IDLE;
         r_start_q  <= 1'b1;
`ifdef SORT_CTRL_STEP_EN
         r_step_q   <= 1'b1;
`endif
         r_swap     <= 1'b0;
         r_err      <= 1'b0;
         r_swap_cnt <= '0;
         r_pass_cnt <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_start_q <= START;
`ifdef SORT_CTRL_STEP_EN
         r_step_q  <= STEP;
`endif
         if (r_state == S_LOAD) begin
            r_swap     <= 1'b0;
            r_err      <= 1'b0;
            r_swap_cnt <= '0;
            r_pass_cnt <= '0;
         end else begin
            if (w_do_swap) begin
               r_swap <= 1'b1;
               if (r_swap_cnt != '1) r_swap_cnt <= r_swap_cnt + 1'b1;
            end
            if (r_state == S_CMP2 && w_adv) begin
               r_swap <= 1'b0;
               if (r_pass_cnt != PASS_MAX) r_pass_cnt <= w_pass_nxt;
               if (w_pass_swapped && w_last) r_err <= 1'b1;
            end
         end
      end
   end

   assign BUSY     = (r_state == S_LOAD) || (r_state == S_CMP0) ||
                     (r_state == S_CMP1) || (r_state == S_CMP2);
   assign DONE     = (r_state == S_DONE);
   assign ERR      = r_err;
   assign SWAP_CNT = r_swap_cnt;
   assign PASS_CNT = r_pass_cnt;

endmodule

// File: doc/sort_ctrl_fsm.md
Name: sort_ctrl_fsm

Overview:
- Sequencing FSM for the 4-entry, 4-bit bubble-sort datapath (SLAVE_CIRCUIT).
- Loads the switch word into the four registers, then runs compare/swap passes on the LT status until one pass makes no swap.
- Drives the datapath SEL/LD controls. Reports BUSY/DONE, swap and pass counts, and an error flag.
- Sort order is descending: arr_0 >= arr_1 >= arr_2 >= arr_3 at completion.

Parameters:
- MAX_PASS, 4, pass limit; pass counter saturation point and error threshold.
- CNT_W, 4, width of SWAP_CNT and PASS_CNT.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- CLR  in  1  asynchronous, active-low reset (0 = reset).
- START  in  1  level from a button; a rising edge is detected internally.
- LT  in  3  datapath comparator status; LT[i] = arr_i < arr_(i+1).
- SEL  out  6  datapath mux selects.
- LD  out  4  datapath register load enables.
- BUSY  out  1  high from LOAD through the last compare state.
- DONE  out  1  high in the DONE state.
- ERR  out  1  set if MAX_PASS passes complete and the last pass still swapped.
- SWAP_CNT  out  CNT_W  swaps performed in the current or last sort.
- PASS_CNT  out  CNT_W  passes performed in the current or last sort.

Behaviour:
- Reset (CLR=0, asynchronous):
  - State = IDLE; SWAP_CNT=0, PASS_CNT=0, ERR=0, swap flag=0.
  - Internal START history register = 1, so a button held through reset does not trigger a sort.
  - Outputs during reset: SEL=0, LD=0, BUSY=0, DONE=0.
- Start detect: start_q is registered each cycle. start_edge = START & ~start_q. It is honoured only in IDLE and DONE and ignored while BUSY.
- States: IDLE, LOAD, CMP0, CMP1, CMP2, DONE.
- IDLE: SEL=0, LD=0. On start_edge go to LOAD.
- LOAD (1 cycle):
  - SEL=000000, LD=1111, so the switches load into all four registers.
  - Clear SWAP_CNT, PASS_CNT, ERR and the swap flag. Go to CMP0.
- SEL/LD in compare states are Mealy outputs (combinational from state and LT). The swap commits on the edge that leaves the state.
- CMP0:
  - If LT[0]: SEL[0]=1, SEL[2:1]=01, LD=0011 (swap arr_0 and arr_1).
  - Else: SEL=0, LD=0.
  - Go to CMP1.
- CMP1:
  - If LT[1]: SEL[2:1]=10, SEL[4:3]=10, LD=0110 (swap arr_1 and arr_2).
  - Else: SEL=0, LD=0.
  - Go to CMP2.
- CMP2:
  - If LT[2]: SEL[4:3]=01, SEL[5]=1, LD=1100 (swap arr_2 and arr_3).
  - Else: SEL=0, LD=0.
  - End of pass: PASS_CNT increments, saturating at MAX_PASS.
  - If the pass swapped (swap flag or LT[2]) and PASS_CNT+1 < MAX_PASS: clear the swap flag, go to CMP0.
  - If the pass swapped and PASS_CNT+1 = MAX_PASS: set ERR, go to DONE.
  - If no swap in the pass: go to DONE.
- Every compare cycle with LT[i]=1 increments SWAP_CNT (saturating at all-ones) and sets the swap flag.
- Each compare state lasts exactly 1 cycle. The comparator reads registers updated by the previous edge.
- DONE:
  - SEL=0, LD=0, DONE=1; counters and ERR hold.
  - On start_edge go to LOAD (re-sort with the new switch value).
- Latency: DONE asserts 1 + 3*PASS_CNT cycles after entering LOAD.
  - Already sorted input: 4 cycles.
  - Worst case (ascending input): 13 cycles.
- Equal keys: LT=0, so equal keys are never swapped; all-equal input completes in 1 pass.
- Reset mid-sort: returns to IDLE immediately. Datapath contents are not restored; the datapath is cleared by its own CLR.

Optional Feature:
- Macro: SORT_CTRL_STEP_EN.
- Defined:
  - Adds input port STEP (1 bit), edge-detected like START.
  - Each compare state holds (SEL=0, LD=0, no count change) until a step edge.
  - On the step edge the state's normal swap/transition logic executes for that single cycle.
  - LOAD and DONE transitions are unaffected.
- Undefined: the STEP port is absent; compare states advance every cycle as above.

Test Plan:
- Already descending: SW=16'h1234 (arr=[4,3,2,1]), model LT=000, START pulse -> LOAD, CMP0-2 with LD=0. DONE after 4 cycles; SWAP_CNT=0, PASS_CNT=1, ERR=0.
- Ascending, with the behavioural datapath in the loop: SW=16'h4321 (arr=[1,2,3,4]) -> final arr=[4,3,2,1]; SWAP_CNT=6, PASS_CNT=4. DONE 13 cycles after LOAD; LD sequence of pass 1 = 0011, 0110, 1100.
- All equal: SW=16'h5555 -> no LD asserted after LOAD; PASS_CNT=1, SWAP_CNT=0.
- Forced LT=111 every cycle (faulty datapath) -> ERR=1, PASS_CNT=4, DONE=1 after 13 cycles.
- START held high across reset release -> no sort. START toggled while BUSY -> ignored, counts unchanged. CLR pulled low in CMP1 -> IDLE, BUSY=0, counters=0 the same cycle.
- SORT_CTRL_STEP_EN with SW=16'h4321 -> state frozen in CMP0 with no STEP; each STEP pulse advances exactly one compare; final result matches the non-step run.
